// File: rtl/inst_mem_loader.sv
// inst_mem_loader: byte-stream programmer that writes a start address plus data bytes into inst_memory
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start, i_stop         1-cycle pulses that begin/restart or end a load transaction
//   i_byte_valid, i_byte    incoming stream byte, accepted when o_byte_ready is high
//   o_byte_ready            loader accepts i_byte this cycle
//   o_mem_address/data/cs   memory write port, cs high one cycle per written byte
//   o_cpu_hold              CPU held while loading, released in DONE
//   o_done                  load finished, held until the next i_start
//   o_overflow              sticky: a data byte targeted an address >= MEM_DEPTH
//   o_byte_count            data bytes written this transaction (saturating)
//   o_checksum              XOR of all bytes written this transaction
module inst_mem_loader #(
    parameter int MEM_DEPTH = 128,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_byte_valid,
    input  logic [DATA_W-1:0] i_byte,
    output logic              o_byte_ready,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_cs,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_overflow,
    output logic [7:0]        o_byte_count,
    output logic [DATA_W-1:0] o_checksum
);
    typedef enum logic [2:0] {S_IDLE, S_GET_ADDR, S_STREAM, S_STROBE, S_DONE} state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_ptr, r_addr;
    logic [DATA_W-1:0] r_data, r_checksum;
    logic [7:0]        r_count;
    logic              r_ready, r_cs, r_hold, r_done, r_overflow;
    logic              w_acc, w_in_range;

    assign w_acc         = i_byte_valid & r_ready;
    assign w_in_range    = {1'b0, r_ptr} < LP_DEPTH;
    assign o_byte_ready  = r_ready;
    assign o_mem_address = r_addr;
    assign o_mem_data    = r_data;
    assign o_mem_cs      = r_cs;
    assign o_cpu_hold    = r_hold;
    assign o_done        = r_done;
    assign o_overflow    = r_overflow;
    assign o_byte_count  = r_count;
    assign o_checksum    = r_checksum;

    // Start beats stop everywhere; a stop during STROBE lets the strobe finish and then goes to DONE.
    always_comb begin
        w_next = r_state;
        if (i_start)
            w_next = S_GET_ADDR;
        else
            case (r_state)
                S_GET_ADDR: w_next = i_stop ? S_DONE : (w_acc ? S_STREAM : S_GET_ADDR);
                S_STREAM:   w_next = i_stop ? S_DONE : ((w_acc && w_in_range) ? S_STROBE : S_STREAM);
                S_STROBE:   w_next = i_stop ? S_DONE : S_STREAM;
                default:    w_next = r_state;
            endcase
    end

    // Handshake/status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_checksum <= '0;
            r_count    <= '0;
            r_ready    <= 1'b0;
            r_cs       <= 1'b0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_GET_ADDR) || (w_next == S_STREAM);
            r_cs    <= w_next == S_STROBE;
            r_hold  <= w_next != S_DONE;
            r_done  <= w_next == S_DONE;
            if (i_start) begin
                r_count    <= '0;
                r_checksum <= '0;
                r_overflow <= 1'b0;
            end else if (r_state == S_STROBE) begin
                r_ptr      <= (&r_ptr) ? r_ptr : r_ptr + 1'b1;
                r_count    <= (&r_count) ? r_count : r_count + 8'd1;
                r_checksum <= r_checksum ^ r_data;
            end else if (w_acc && !i_stop) begin
                // A stop arriving with a byte ends the transaction; the byte is not used.
                if (r_state == S_GET_ADDR)
                    r_ptr <= ADDR_W'(i_byte);
                else if (w_in_range) begin
                    r_addr <= r_ptr;
                    r_data <= i_byte;
                end else
                    r_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed self-checking bench for inst_mem_loader
module tb_inst_mem_loader;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_byte_valid = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       o_byte_ready, o_mem_cs, o_cpu_hold, o_done, o_overflow;
    logic [7:0] o_mem_address, o_mem_data, o_byte_count, o_checksum;

    int checks = 0;
    int errors = 0;
    logic [7:0] wa[$];
    logic [7:0] wd[$];

    inst_mem_loader dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
        .o_mem_address(o_mem_address), .o_mem_data(o_mem_data), .o_mem_cs(o_mem_cs),
        .o_cpu_hold(o_cpu_hold), .o_done(o_done), .o_overflow(o_overflow),
        .o_byte_count(o_byte_count), .o_checksum(o_checksum)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk)
        if (o_mem_cs) begin
            wa.push_back(o_mem_address);
            wd.push_back(o_mem_data);
        end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!o_byte_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n == 20) begin
            errors++;
            $display("FAIL send_timeout: ready=%b required 1 within 20 cycles", o_byte_ready);
            return;
        end
        i_byte_valid = 1'b1;
        i_byte = b;
        tick();
        i_byte_valid = 1'b0;
    endtask

    // {ready, cs, hold, done, overflow}
    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({o_byte_ready, o_mem_cs, o_cpu_hold, o_done, o_overflow} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00100", {o_byte_ready, o_mem_cs, o_cpu_hold, o_done, o_overflow});
        end
        checks++;
        if ({o_byte_count, o_checksum, o_mem_address, o_mem_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 00000000", {o_byte_count, o_checksum, o_mem_address, o_mem_data});
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        logic [7:0] exp_d[4] = '{8'h13, 8'h05, 8'h10, 8'h00};
        wa.delete();
        wd.delete();
        pulse_start();
        checks++;
        if ({o_byte_ready, o_cpu_hold, o_done} !== 3'b110) begin
            errors++;
            $display("FAIL basic_get_addr: got %b required 110", {o_byte_ready, o_cpu_hold, o_done});
        end
        send(8'h00);
        send(8'h13);
        checks++;
        if ({o_mem_cs, o_byte_ready, o_mem_address, o_mem_data} !== {2'b10, 8'h00, 8'h13}) begin
            errors++;
            $display("FAIL basic_first_strobe: got %h required %h", {o_mem_cs, o_byte_ready, o_mem_address, o_mem_data}, {2'b10, 8'h00, 8'h13});
        end
        tick();
        checks++;
        if ({o_mem_cs, o_byte_ready, o_mem_address, o_mem_data} !== {2'b01, 8'h00, 8'h13}) begin
            errors++;
            $display("FAIL basic_after_strobe: got %h required %h", {o_mem_cs, o_byte_ready, o_mem_address, o_mem_data}, {2'b01, 8'h00, 8'h13});
        end
        send(8'h05);
        send(8'h10);
        send(8'h00);
        tick();
        pulse_stop();
        checks++;
        if ({o_byte_ready, o_mem_cs, o_cpu_hold, o_done} !== 4'b0001) begin
            errors++;
            $display("FAIL basic_done_flags: got %b required 0001", {o_byte_ready, o_mem_cs, o_cpu_hold, o_done});
        end
        checks++;
        if ({o_byte_count, o_checksum} !== 16'h0406) begin
            errors++;
            $display("FAIL basic_count_sum: got %h required 0406", {o_byte_count, o_checksum});
        end
        checks++;
        if (wa.size() != 4) begin
            errors++;
            $display("FAIL basic_write_count: got %0d required 4", wa.size());
        end else
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({wa[i], wd[i]} !== {8'(i), exp_d[i]}) begin
                    errors++;
                    $display("FAIL basic_write_%0d: got %h required %h", i, {wa[i], wd[i]}, {8'(i), exp_d[i]});
                end
            end
    endtask

    task automatic test_overflow();
        wa.delete();
        wd.delete();
        pulse_start();
        send(8'h7E);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        checks++;
        if ({o_mem_cs, o_overflow, o_byte_ready} !== 3'b011) begin
            errors++;
            $display("FAIL ovf_drop: got cs/ovf/ready %b required 011", {o_mem_cs, o_overflow, o_byte_ready});
        end
        pulse_stop();
        checks++;
        if ({o_done, o_overflow, o_byte_count, o_checksum} !== {2'b11, 8'h02, 8'h11}) begin
            errors++;
            $display("FAIL ovf_result: got %h required %h", {o_done, o_overflow, o_byte_count, o_checksum}, {2'b11, 8'h02, 8'h11});
        end
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL ovf_write_count: got %0d required 2", wa.size());
        end else begin
            checks++;
            if ({wa[0], wd[0], wa[1], wd[1]} !== 32'h7EAA7FBB) begin
                errors++;
                $display("FAIL ovf_writes: got %h required 7eaa7fbb", {wa[0], wd[0], wa[1], wd[1]});
            end
        end
    endtask

    task automatic test_stop_in_strobe();
        wa.delete();
        wd.delete();
        pulse_start();
        checks++;
        if ({o_overflow, o_done, o_cpu_hold} !== 3'b001) begin
            errors++;
            $display("FAIL stop_restart_clear: got ovf/done/hold %b required 001", {o_overflow, o_done, o_cpu_hold});
        end
        send(8'h0A);
        send(8'h5A);
        checks++;
        if ({o_mem_cs, o_mem_address, o_mem_data} !== {1'b1, 8'h0A, 8'h5A}) begin
            errors++;
            $display("FAIL stop_strobe: got %h required %h", {o_mem_cs, o_mem_address, o_mem_data}, {1'b1, 8'h0A, 8'h5A});
        end
        pulse_stop();
        checks++;
        if ({o_mem_cs, o_done, o_cpu_hold, o_byte_count, o_checksum} !== {3'b010, 8'h01, 8'h5A}) begin
            errors++;
            $display("FAIL stop_done: got %h required %h", {o_mem_cs, o_done, o_cpu_hold, o_byte_count, o_checksum}, {3'b010, 8'h01, 8'h5A});
        end
        checks++;
        if (wa.size() != 1) begin
            errors++;
            $display("FAIL stop_write_count: got %0d required 1", wa.size());
        end
    endtask

    task automatic test_restart();
        pulse_start();
        send(8'h20);
        send(8'h01);
        send(8'h02);
        tick();
        checks++;
        if ({o_byte_count, o_checksum} !== 16'h0203) begin
            errors++;
            $display("FAIL restart_pre: got %h required 0203", {o_byte_count, o_checksum});
        end
        pulse_start();
        checks++;
        if ({o_byte_ready, o_cpu_hold, o_done, o_byte_count, o_checksum} !== {3'b110, 16'h0000}) begin
            errors++;
            $display("FAIL restart_clear: got %h required %h", {o_byte_ready, o_cpu_hold, o_done, o_byte_count, o_checksum}, {3'b110, 16'h0000});
        end
        i_start = 1'b1;
        i_stop = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop = 1'b0;
        checks++;
        if ({o_byte_ready, o_cpu_hold, o_done} !== 3'b110) begin
            errors++;
            $display("FAIL start_beats_stop: got %b required 110", {o_byte_ready, o_cpu_hold, o_done});
        end
    endtask

    task automatic test_rst_in_strobe();
        send(8'h30);
        send(8'h77);
        checks++;
        if (o_mem_cs !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_cs: got %b required 1", o_mem_cs);
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if ({o_byte_ready, o_mem_cs, o_cpu_hold, o_done, o_overflow, o_byte_count, o_checksum, o_mem_address, o_mem_data} !== {5'b00100, 32'h0}) begin
            errors++;
            $display("FAIL rst_mid_strobe: got %h required %h", {o_byte_ready, o_mem_cs, o_cpu_hold, o_done, o_overflow, o_byte_count, o_checksum, o_mem_address, o_mem_data}, {5'b00100, 32'h0});
        end
        tick();
        checks++;
        if (o_byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: got ready %b required 0", o_byte_ready);
        end
        pulse_start();
        checks++;
        if (o_byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_then_start: got ready %b required 1", o_byte_ready);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic_load();
        test_overflow();
        test_stop_in_strobe();
        test_restart();
        test_rst_in_strobe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
